// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage Y86-64 core.
// Produces same-cycle stall/bubble requests for the F/D/E/M/W pipeline
// registers, gates condition-code writes on exceptions, runs the
// IDLE/RUN/HALTED run-state machine and keeps saturating event counters.
module pipe_ctrl #(
   parameter int         CNT_W = 32,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       W_icode,
   input  logic [3:0]       E_dstM,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic             e_Cnd,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc_en,
   output logic [1:0]       run_state,
   output logic [2:0]       final_stat,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic [CNT_W-1:0] ret_stall_cnt
);

   // Instruction codes
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_POPQ  = 4'hB;

   // Status codes
   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_ADR = 3'd2;
   localparam logic [2:0] S_INS = 3'd3;
   localparam logic [2:0] S_HLT = 3'd4;

   // Run states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // A status that ends execution once it retires.
   function automatic logic is_exc(input logic [2:0] stat);
      logic res;
      case (stat)
         S_ADR:   res = 1'b1;
         S_INS:   res = 1'b1;
         S_HLT:   res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                input logic en);
      logic [CNT_W-1:0] res;
      if (en && (val != CNT_MAX)) begin
         res = val + CNT_ONE;
      end else begin
         res = val;
      end
      return res;
   endfunction

   logic             w_lu;
   logic             w_rt;
   logic             w_mp;
   logic             w_m_exc;
   logic             w_w_exc;
   logic             w_running;
   logic             w_retire;
   logic [1:0]       w_state_nxt;
   logic [2:0]       w_final_nxt;

   logic [1:0]       r_state;
   logic [2:0]       r_final;
   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_lu;
   logic [CNT_W-1:0] r_mp;
   logic [CNT_W-1:0] r_rt;

   // Hazard detection terms from the current pipeline register contents.
   always_comb begin
      w_lu      = ((E_icode == I_MRMOV) || (E_icode == I_POPQ)) &&
                  (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      w_rt      = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
      w_mp      = (E_icode == I_JXX) && !e_Cnd;
      w_m_exc   = is_exc(m_stat);
      w_w_exc   = is_exc(W_stat);
      w_running = (r_state == ST_RUN);
      w_retire  = (W_stat == S_AOK) && (W_icode != I_NOP);
   end

   // Stall/bubble/CC-enable: hazard resolution in RUN, frozen pipeline otherwise.
   always_comb begin
      F_stall   = 1'b1;
      D_stall   = 1'b1;
      D_bubble  = 1'b0;
      E_bubble  = 1'b0;
      M_bubble  = 1'b0;
      W_stall   = 1'b1;
      set_cc_en = 1'b0;
      if (w_running) begin
         // Load-use stall beats the ret bubble so D is never both held and cleared.
         F_stall   = w_lu | w_rt;
         D_stall   = w_lu;
         D_bubble  = w_mp | (w_rt & ~w_lu);
         E_bubble  = w_mp | w_lu;
         M_bubble  = w_m_exc | w_w_exc;
         W_stall   = w_w_exc;
         set_cc_en = (E_icode == I_OPQ) & ~w_m_exc & ~w_w_exc;
      end else begin
         F_stall   = 1'b1;
         D_stall   = 1'b1;
         W_stall   = 1'b1;
      end
   end

   // Next run state and the status latched on the way into HALTED.
   always_comb begin
      w_state_nxt = r_state;
      w_final_nxt = r_final;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_w_exc) begin
               w_state_nxt = ST_HALTED;
               w_final_nxt = W_stat;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_HALTED: begin
            w_state_nxt = ST_HALTED;
         end
         default: begin
            // Unreachable encoding: park safely with the pipeline frozen.
            w_state_nxt = ST_HALTED;
         end
      endcase
   end

   // Run-state and final-status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_final <= S_AOK;
      end else begin
         r_state <= w_state_nxt;
         r_final <= w_final_nxt;
      end
   end

   // Saturating event counters, advanced only while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle   <= {CNT_W{1'b0}};
         r_retired <= {CNT_W{1'b0}};
         r_lu      <= {CNT_W{1'b0}};
         r_mp      <= {CNT_W{1'b0}};
         r_rt      <= {CNT_W{1'b0}};
      end else if (w_running) begin
         r_cycle   <= sat_inc(r_cycle, 1'b1);
         r_retired <= sat_inc(r_retired, w_retire);
         r_lu      <= sat_inc(r_lu, w_lu);
         r_mp      <= sat_inc(r_mp, w_mp);
         r_rt      <= sat_inc(r_rt, w_rt & ~w_lu);
      end
   end

   assign run_state     = r_state;
   assign final_stat    = r_final;
   assign cycle_cnt     = r_cycle;
   assign retired_cnt   = r_retired;
   assign lu_stall_cnt  = r_lu;
   assign mispred_cnt   = r_mp;
   assign ret_stall_cnt = r_rt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// runs, all compared against a behavioural model of the control rules.
module tb_pipe_ctrl;

   localparam int CW   = 5;                // narrow counters so saturation is reachable
   localparam int MAXC = (1 << CW) - 1;
   localparam logic [6:0] IDLE_OUTS = 7'b1100010;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [3:0]    D_icode, E_icode, M_icode, W_icode;
   logic [3:0]    E_dstM, d_srcA, d_srcB;
   logic          e_Cnd;
   logic [2:0]    m_stat, W_stat;
   logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en;
   logic [1:0]    run_state;
   logic [2:0]    final_stat;
   logic [CW-1:0] cycle_cnt, retired_cnt, lu_stall_cnt, mispred_cnt, ret_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   int       m_state;
   int       m_final;
   int       m_cyc, m_ret, m_lu, m_mp, m_rt;

   pipe_ctrl #(.CNT_W(CW), .RNONE(4'hF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
      .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .M_bubble(M_bubble), .W_stall(W_stall), .set_cc_en(set_cc_en),
      .run_state(run_state), .final_stat(final_stat),
      .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .lu_stall_cnt(lu_stall_cnt),
      .mispred_cnt(mispred_cnt), .ret_stall_cnt(ret_stall_cnt)
   );

   wire [6:0] dut_outs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en};
   wire [5*CW+4:0] dut_regs = {run_state, final_stat, cycle_cnt, retired_cnt,
                               lu_stall_cnt, mispred_cnt, ret_stall_cnt};

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, need finish");
      $fatal(1, "timeout");
   end

   function automatic bit exc(input logic [2:0] s);
      return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
   endfunction

   function automatic bit m_lu_f();
      return ((E_icode == 4'd5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   endfunction

   function automatic bit m_rt_f();
      return (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
   endfunction

   function automatic bit m_mp_f();
      return (E_icode == 4'd7) && !e_Cnd;
   endfunction

   // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc_en}
   function automatic logic [6:0] model_outs();
      bit lu, rt, mp;
      lu = m_lu_f();
      rt = m_rt_f();
      mp = m_mp_f();
      if (m_state != 1) return IDLE_OUTS;
      return {lu | rt, lu, mp | (rt & !lu), mp | lu,
              exc(m_stat) | exc(W_stat), exc(W_stat),
              (E_icode == 4'd6) && !exc(m_stat) && !exc(W_stat)};
   endfunction

   function automatic logic [5*CW+4:0] model_regs();
      logic [1:0] st;
      logic [2:0] fs;
      logic [CW-1:0] c0, c1, c2, c3, c4;
      st = 2'(m_state); fs = 3'(m_final);
      c0 = CW'(m_cyc); c1 = CW'(m_ret); c2 = CW'(m_lu); c3 = CW'(m_mp); c4 = CW'(m_rt);
      return {st, fs, c0, c1, c2, c3, c4};
   endfunction

   function automatic int sat(input int v, input bit en);
      return (en && v < MAXC) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_final = 1;
      m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0; m_rt = 0;
   endtask

   // Advance the model by one clock edge using the current inputs.
   task automatic model_step();
      bit lu, rt, mp;
      lu = m_lu_f(); rt = m_rt_f(); mp = m_mp_f();
      if (m_state == 1) begin
         m_cyc = sat(m_cyc, 1'b1);
         m_ret = sat(m_ret, (W_stat == 3'd1) && (W_icode != 4'd1));
         m_lu  = sat(m_lu, lu);
         m_mp  = sat(m_mp, mp);
         m_rt  = sat(m_rt, rt && !lu);
         if (exc(W_stat)) begin
            m_state = 2;
            m_final = int'(W_stat);
         end
      end else if (m_state == 0 && start) begin
         m_state = 1;
      end
   endtask

   // One clock: update model, cross the rising edge, return at the falling edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_in();
      start = 1'b0;
      D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1; W_icode = 4'd1;
      E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
      e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
   endtask

   // Assert reset mid-cycle and leave it asserted.
   task automatic assert_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 model_reset();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic go_run();
      assert_reset();
      clr_in();
      release_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic rand_in(input bit allow_exc);
      logic [3:0] tab [8];
      int r;
      tab[0] = 4'd1; tab[1] = 4'd5; tab[2] = 4'd6; tab[3] = 4'd7;
      tab[4] = 4'd9; tab[5] = 4'hB; tab[6] = 4'd2; tab[7] = 4'd3;
      D_icode = tab[$urandom_range(0, 7)];
      E_icode = tab[$urandom_range(0, 7)];
      M_icode = tab[$urandom_range(0, 7)];
      W_icode = tab[$urandom_range(0, 7)];
      r = int'($urandom_range(0, 4)); E_dstM = (r == 4) ? 4'hF : 4'(r);
      r = int'($urandom_range(0, 4)); d_srcA = (r == 4) ? 4'hF : 4'(r);
      r = int'($urandom_range(0, 4)); d_srcB = (r == 4) ? 4'hF : 4'(r);
      e_Cnd = 1'($urandom_range(0, 1));
      m_stat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      if (allow_exc && $urandom_range(0, 24) == 0) W_stat = 3'($urandom_range(2, 4));
      else if ($urandom_range(0, 9) == 0) W_stat = 3'($urandom_range(5, 7));
      else W_stat = 3'd1;
      start = ($urandom_range(0, 9) == 0);
   endtask

   task automatic test_reset();
      assert_reset();
      clr_in();
      release_reset();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin rand_in(1'b0); start = 1'b0; tick(); end
      assert_reset();
      n_tests++;
      if (dut_outs !== IDLE_OUTS) begin
         n_fail++; $display("FAIL reset_outs: got %b need %b", dut_outs, IDLE_OUTS);
      end
      n_tests++;
      if (dut_regs !== model_regs()) begin
         n_fail++; $display("FAIL reset_regs: got %h need %h", dut_regs, model_regs());
      end
      clr_in();
      release_reset();
      for (int i = 0; i < 10; i++) tick();
      n_tests++;
      if (cycle_cnt !== 0 || run_state !== 2'd0 || dut_outs !== IDLE_OUTS) begin
         n_fail++; $display("FAIL idle_hold: got cyc=%0d st=%0d outs=%b need 0 0 %b",
                            cycle_cnt, run_state, dut_outs, IDLE_OUTS);
      end
   endtask

   task automatic test_load_use();
      go_run();
      E_icode = 4'd5; E_dstM = 4'd3; d_srcB = 4'd3;
      #1;
      n_tests++;
      if (dut_outs !== model_outs() || dut_outs[6:3] !== 4'b1101) begin
         n_fail++; $display("FAIL load_use_outs: got %b need %b", dut_outs, model_outs());
      end
      tick();
      n_tests++;
      if (lu_stall_cnt !== 1 || dut_regs !== model_regs()) begin
         n_fail++; $display("FAIL load_use_cnt: got %0d need 1", lu_stall_cnt);
      end
      E_dstM = 4'hF; d_srcB = 4'hF;
      #1;
      n_tests++;
      if (dut_outs !== model_outs() || dut_outs[6:3] !== 4'b0000) begin
         n_fail++; $display("FAIL load_use_rnone: got %b need %b", dut_outs, model_outs());
      end
      tick();
   endtask

   task automatic test_mispredict();
      go_run();
      E_icode = 4'd7; e_Cnd = 1'b0;
      #1;
      n_tests++;
      if (dut_outs !== model_outs() || dut_outs[6:3] !== 4'b0011) begin
         n_fail++; $display("FAIL mispred_outs: got %b need %b", dut_outs, model_outs());
      end
      tick();
      n_tests++;
      if (mispred_cnt !== 1 || dut_regs !== model_regs()) begin
         n_fail++; $display("FAIL mispred_cnt: got %0d need 1", mispred_cnt);
      end
      e_Cnd = 1'b1;
      #1;
      n_tests++;
      if (dut_outs !== model_outs() || dut_outs[4:3] !== 2'b00) begin
         n_fail++; $display("FAIL mispred_taken: got %b need %b", dut_outs, model_outs());
      end
      tick();
   endtask

   task automatic test_ret();
      go_run();
      for (int i = 0; i < 3; i++) begin
         D_icode = (i == 0) ? 4'd9 : 4'd1;
         E_icode = (i == 1) ? 4'd9 : 4'd1;
         M_icode = (i == 2) ? 4'd9 : 4'd1;
         #1;
         n_tests++;
         if (dut_outs !== model_outs() || F_stall !== 1'b1 || D_bubble !== 1'b1) begin
            n_fail++; $display("FAIL ret_outs%0d: got %b need %b", i, dut_outs, model_outs());
         end
         tick();
      end
      n_tests++;
      if (ret_stall_cnt !== 3) begin
         n_fail++; $display("FAIL ret_cnt: got %0d need 3", ret_stall_cnt);
      end
      D_icode = 4'd9; M_icode = 4'd1; E_icode = 4'hB; E_dstM = 4'd3; d_srcA = 4'd3;
      #1;
      n_tests++;
      if (dut_outs !== model_outs() || D_stall !== 1'b1 || D_bubble !== 1'b0) begin
         n_fail++; $display("FAIL ret_lu_outs: got %b need %b", dut_outs, model_outs());
      end
      tick();
      n_tests++;
      if (ret_stall_cnt !== 3 || lu_stall_cnt !== 1 || dut_regs !== model_regs()) begin
         n_fail++; $display("FAIL ret_lu_cnt: got rt=%0d lu=%0d need 3 1",
                            ret_stall_cnt, lu_stall_cnt);
      end
   endtask

   task automatic test_exception();
      go_run();
      m_stat = 3'd2; E_icode = 4'd6;
      #1;
      n_tests++;
      if (dut_outs !== model_outs() || M_bubble !== 1'b1 || set_cc_en !== 1'b0) begin
         n_fail++; $display("FAIL exc_mstat: got %b need %b", dut_outs, model_outs());
      end
      tick();
      m_stat = 3'd1; E_icode = 4'd1; W_stat = 3'd4;
      #1;
      n_tests++;
      if (dut_outs !== model_outs() || W_stall !== 1'b1) begin
         n_fail++; $display("FAIL exc_wstat: got %b need %b", dut_outs, model_outs());
      end
      tick();
      n_tests++;
      if (run_state !== 2'd2 || final_stat !== 3'd4 || dut_regs !== model_regs()) begin
         n_fail++; $display("FAIL exc_halt: got st=%0d fs=%0d need 2 4", run_state, final_stat);
      end
      for (int i = 0; i < 6; i++) begin
         rand_in(1'b1);
         start = (i == 2);
         tick();
      end
      n_tests++;
      if (run_state !== 2'd2 || dut_regs !== model_regs() || dut_outs !== IDLE_OUTS) begin
         n_fail++; $display("FAIL exc_frozen: got %h need %h", dut_regs, model_regs());
      end
   endtask

   task automatic test_retire();
      logic [3:0] seq [5];
      seq[0] = 4'd3; seq[1] = 4'd1; seq[2] = 4'd6; seq[3] = 4'd1; seq[4] = 4'd2;
      go_run();
      for (int i = 0; i < 5; i++) begin
         W_stat = 3'd1; W_icode = seq[i];
         tick();
      end
      n_tests++;
      if (retired_cnt !== 3 || cycle_cnt !== 5) begin
         n_fail++; $display("FAIL retire: got ret=%0d cyc=%0d need 3 5", retired_cnt, cycle_cnt);
      end
   endtask

   task automatic test_random();
      for (int round = 0; round < 3; round++) begin
         go_run();
         for (int i = 0; i < 45; i++) begin
            rand_in(round != 0);
            #1;
            n_tests++;
            if (dut_outs !== model_outs()) begin
               n_fail++; $display("FAIL rand_outs r%0d c%0d: got %b need %b",
                                  round, i, dut_outs, model_outs());
            end
            tick();
            n_tests++;
            if (dut_regs !== model_regs()) begin
               n_fail++; $display("FAIL rand_regs r%0d c%0d: got %h need %h",
                                  round, i, dut_regs, model_regs());
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clr_in();
      model_reset();
      test_reset();
      test_load_use();
      test_mispredict();
      test_ret();
      test_exception();
      test_retire();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage Y86-64 processor. Each cycle it raises the stall and bubble requests for the F, D, E, M and W pipeline registers to resolve load-use hazards, ret hazards and mispredicted jumps. It gates condition-code updates on exceptions. A run-state FSM freezes the pipeline once an exception or halt retires. It also keeps cycle and event counters for the testbench and debug.

Parameters:
CNT_W, 32, width of every performance counter
RNONE, 4'hF, register ID meaning "no register"

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves IDLE and begins execution
D_icode  in  4  icode in the D pipeline register
E_icode  in  4  icode in the E pipeline register
M_icode  in  4  icode in the M pipeline register
W_icode  in  4  icode in the W pipeline register
E_dstM  in  4  load destination register in E
d_srcA  in  4  srcA decoded in D
d_srcB  in  4  srcB decoded in D
e_Cnd  in  1  condition result computed in E
m_stat  in  3  status produced by the memory stage
W_stat  in  3  status in the W pipeline register
F_stall  out  1  hold the F register (predPC)
D_stall  out  1  hold the D register
D_bubble  out  1  load nop into the D register
E_bubble  out  1  load nop into the E register
M_bubble  out  1  load nop into the M register
W_stall  out  1  hold the W register
set_cc_en  out  1  allow a CC write from the E-stage OPq
run_state  out  2  0=IDLE, 1=RUN, 2=HALTED
final_stat  out  3  W_stat captured on entry to HALTED
cycle_cnt  out  CNT_W  cycles spent in RUN
retired_cnt  out  CNT_W  instructions retired
lu_stall_cnt  out  CNT_W  load-use stall cycles
mispred_cnt  out  CNT_W  mispredicted jumps
ret_stall_cnt  out  CNT_W  ret-bubble cycles

Behaviour:
- Encodings: icode JXX=7, CALL=8, RET=9, MRMOV=5, POPQ=B, OPQ=6, NOP=1. Stat AOK=1, ADR=2, INS=3, HLT=4. "exc(s)" means s is ADR, INS or HLT.
- Combinational hazard terms:
  - lu = (E_icode is MRMOV or POPQ) && E_dstM != RNONE && (E_dstM == d_srcA || E_dstM == d_srcB)
  - rt = RET in any of D_icode, E_icode, M_icode
  - mp = E_icode == JXX && !e_Cnd
- Outputs while in RUN:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (rt & !lu)
  - E_bubble = mp | lu
  - M_bubble = exc(m_stat) | exc(W_stat)
  - W_stall = exc(W_stat)
  - set_cc_en = (E_icode == OPQ) & !exc(m_stat) & !exc(W_stat)
- Priority: when lu and rt occur together, the stall wins and D is not bubbled. When mp and lu occur together, D_bubble=1 and E_bubble=1. No output ever asserts stall and bubble on the same register.
- IDLE and HALTED: F_stall=D_stall=W_stall=1, every bubble=0, set_cc_en=0.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> HALTED on the first cycle with exc(W_stat); final_stat <= W_stat on that edge.
  - HALTED is left only by reset; start is ignored there.
  - start while in RUN is ignored.
- Counters: increment only while run_state==RUN and never wrap (saturate at all-ones).
  - cycle_cnt +1 every RUN cycle, including the cycle that leaves RUN.
  - retired_cnt +1 when W_stat==AOK && W_icode != NOP. Bubbles are nops and are therefore not counted.
  - lu_stall_cnt +1 when lu; mispred_cnt +1 when mp; ret_stall_cnt +1 when rt & !lu.
- Reset (rst_n low, any time, asynchronous):
  - run_state=IDLE, final_stat=AOK, all counters 0.
  - Outputs immediately take their IDLE values (stalls=1, bubbles=0, set_cc_en=0).
  - Reset in the middle of RUN discards all state; there is no draining.
- Latency: stall/bubble/set_cc_en are same-cycle combinational. run_state, final_stat and the counters update on the rising clk edge.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle -> run_state=0, F_stall=D_stall=W_stall=1, all counters 0; 10 cycles without start -> cycle_cnt stays 0.
- Load-use: RUN, E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; held 1 cycle -> lu_stall_cnt=1. Repeat with E_dstM=F -> no stall.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0, mispred_cnt increments. With e_Cnd=1 -> no bubbles.
- Ret: D_icode, E_icode, then M_icode=9 on 3 consecutive cycles -> F_stall=1, D_bubble=1 each cycle, ret_stall_cnt=3. Same with lu also true -> D_stall=1, D_bubble=0, ret_stall_cnt unchanged.
- Exception/halt: m_stat=2 with E_icode=6 -> M_bubble=1, set_cc_en=0. Next cycle W_stat=4 -> W_stall=1; after the edge run_state=2, final_stat=4, counters frozen; a later start pulse has no effect.
- Retire count: 5 cycles of W_stat=1 with W_icode sequence 3,1,6,1,2 -> retired_cnt=3, cycle_cnt=5.
